readout_deserializer: RTL

Receive-side counterpart of the cores' shared serial readout. When `ud_en` falls, the cores stop counting and shift their I/Q counter words out on the shared `read_out_I[1:0]` / `read_out_Q[1:0]` lines. This block sits on the RISC side of the level shifters. It samples the four lanes and reassembles each time slot into four parallel words. It then hands each slot to firmware through a valid/ready holding register.

---
 rtl/readout_pkg.sv | 25 ++
 rtl/readout_lane_shift.sv | 50 +++++
 rtl/readout_deserializer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/readout_pkg.sv
// Shared types and constants for the serial readout deserializer.
// READOUT_PARITY_EN adds a trailing even-parity bit to every lane word.
package readout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT,
    ST_DONE
  } state_e;

  localparam int unsigned LANE_I0 = 0;
  localparam int unsigned LANE_I1 = 1;
  localparam int unsigned LANE_Q0 = 2;
  localparam int unsigned LANE_Q1 = 3;

  function automatic int unsigned word_bits(input int unsigned width);
`ifdef READOUT_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/readout_lane_shift.sv
// One serial lane: MSB-first shift register whose word output already includes
// the bit being sampled this cycle. Parity check built only with READOUT_PARITY_EN.
module readout_lane_shift
  import readout_pkg::*;
#(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             shift_en_i,
  input  logic             clr_i,
  input  logic             ser_i,
`ifdef READOUT_PARITY_EN
  output logic             par_ok_o,
`endif
  output logic [WIDTH-1:0] word_o
);

  localparam int unsigned WB = word_bits(WIDTH);

  // Only WB-1 bits are stored; the final bit is taken live from ser_i so the
  // completed word is available on the cycle its last bit is sampled.
  logic [WB-2:0] sr_q, sr_d;
  logic [WB-1:0] full;

  assign full   = {sr_q, ser_i};
  assign word_o = full[WB-1 -: WIDTH];

`ifdef READOUT_PARITY_EN
  assign par_ok_o = ~^full;
`endif

  always_comb begin
    sr_d = sr_q;
    if (clr_i) begin
      sr_d = '0;
    end else if (shift_en_i) begin
      sr_d = full[WB-2:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/readout_deserializer.sv
// Reassembles the cores' shared serial I/Q readout into per-slot parallel words
// behind a valid/ready holding register. READOUT_PARITY_EN enables the err_par port.
module readout_deserializer
  import readout_pkg::*;
#(
  parameter int unsigned WIDTH   = 10,
  parameter int unsigned N_SLOTS = 8,
  parameter int unsigned LEAD    = 2
) (
  input  logic                       clk_master,
  input  logic                       rst,
  input  logic                       ud_en,
  input  logic [1:0]                 read_out_I,
  input  logic [1:0]                 read_out_Q,
  output logic [4*WIDTH-1:0]         out_data,
  output logic [$clog2(N_SLOTS)-1:0] out_slot,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       err_ovf,
  output logic                       err_abort
`ifdef READOUT_PARITY_EN
  ,
  output logic                       err_par
`endif
);

  localparam int unsigned WB     = word_bits(WIDTH);
  localparam int unsigned BIT_W  = $clog2(WB);
  localparam int unsigned SLOT_W = $clog2(N_SLOTS);
  localparam int unsigned LCNT_W = (LEAD > 2) ? $clog2(LEAD - 1) : 1;

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WB - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(N_SLOTS - 1);
  localparam logic [LCNT_W-1:0] LEAD_LAST = LCNT_W'((LEAD > 2) ? LEAD - 2 : 0);

  state_e              state_q, state_d;
  logic                ud_en_q, ud_primed_q;
  logic [LCNT_W-1:0]   lead_cnt_q, lead_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SLOT_W-1:0]   slot_cnt_q, slot_cnt_d;
  logic [4*WIDTH-1:0]  hold_data_q, hold_data_d;
  logic [SLOT_W-1:0]   hold_slot_q, hold_slot_d;
  logic                hold_valid_q, hold_valid_d;
  logic                done_q, done_d;
  logic                err_ovf_q, err_ovf_d;
  logic                err_abort_q, err_abort_d;

  logic                fall, rise, slot_done;
  logic                lane_shift, lane_clr;
  logic [3:0]          lane_in;
  logic [WIDTH-1:0]    lane_word [4];

`ifdef READOUT_PARITY_EN
  logic                err_par_q, err_par_d;
  logic [3:0]          lane_par_ok;
`endif

  // ud_en_q resets high; the primed flag keeps the first post-reset cycle from
  // reading a level that is already low as a falling edge.
  assign fall = ud_primed_q & ud_en_q & ~ud_en;
  assign rise = ~ud_en_q & ud_en;

  assign lane_in[LANE_I0] = read_out_I[0];
  assign lane_in[LANE_I1] = read_out_I[1];
  assign lane_in[LANE_Q0] = read_out_Q[0];
  assign lane_in[LANE_Q1] = read_out_Q[1];

  for (genvar g = 0; g < 4; g++) begin : g_lane
    readout_lane_shift #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk_i      (clk_master),
      .rst_i      (rst),
      .shift_en_i (lane_shift),
      .clr_i      (lane_clr),
      .ser_i      (lane_in[g]),
`ifdef READOUT_PARITY_EN
      .par_ok_o   (lane_par_ok[g]),
`endif
      .word_o     (lane_word[g])
    );
  end

  always_comb begin
    state_d      = state_q;
    lead_cnt_d   = lead_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    slot_cnt_d   = slot_cnt_q;
    hold_data_d  = hold_data_q;
    hold_slot_d  = hold_slot_q;
    hold_valid_d = hold_valid_q;
    done_d       = 1'b0;
    err_ovf_d    = err_ovf_q;
    err_abort_d  = err_abort_q;
`ifdef READOUT_PARITY_EN
    err_par_d    = err_par_q;
`endif
    lane_shift   = 1'b0;
    lane_clr     = 1'b0;
    slot_done    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d     = (LEAD > 1) ? ST_LEAD : ST_SHIFT;
          lead_cnt_d  = '0;
          bit_cnt_d   = '0;
          slot_cnt_d  = '0;
          err_ovf_d   = 1'b0;
          err_abort_d = 1'b0;
`ifdef READOUT_PARITY_EN
          err_par_d   = 1'b0;
`endif
          lane_clr    = 1'b1;
        end
      end
      ST_LEAD: begin
        if (rise) begin
          state_d     = ST_IDLE;
          err_abort_d = 1'b1;
          lane_clr    = 1'b1;
        end else if (lead_cnt_q == LEAD_LAST) begin
          state_d = ST_SHIFT;
        end else begin
          lead_cnt_d = lead_cnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (rise) begin
          state_d     = ST_IDLE;
          err_abort_d = 1'b1;
          lane_clr    = 1'b1;
        end else begin
          lane_shift = 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            slot_done = 1'b1;
            if (slot_cnt_q == SLOT_LAST) begin
              state_d = ST_DONE;
            end else begin
              slot_cnt_d = slot_cnt_q + 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // A completing slot may replace held data only if that data leaves this cycle.
    if (slot_done) begin
      if (!hold_valid_q || out_ready) begin
        hold_valid_d = 1'b1;
        hold_data_d  = {lane_word[LANE_Q1], lane_word[LANE_Q0],
                        lane_word[LANE_I1], lane_word[LANE_I0]};
        hold_slot_d  = slot_cnt_q;
      end else begin
        err_ovf_d = 1'b1;
      end
    end else if (hold_valid_q && out_ready) begin
      hold_valid_d = 1'b0;
    end

`ifdef READOUT_PARITY_EN
    if (slot_done && !(&lane_par_ok)) begin
      err_par_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_master) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ud_en_q      <= 1'b1;
      ud_primed_q  <= 1'b0;
      lead_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      slot_cnt_q   <= '0;
      hold_data_q  <= '0;
      hold_slot_q  <= '0;
      hold_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_ovf_q    <= 1'b0;
      err_abort_q  <= 1'b0;
`ifdef READOUT_PARITY_EN
      err_par_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ud_en_q      <= ud_en;
      ud_primed_q  <= 1'b1;
      lead_cnt_q   <= lead_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      slot_cnt_q   <= slot_cnt_d;
      hold_data_q  <= hold_data_d;
      hold_slot_q  <= hold_slot_d;
      hold_valid_q <= hold_valid_d;
      done_q       <= done_d;
      err_ovf_q    <= err_ovf_d;
      err_abort_q  <= err_abort_d;
`ifdef READOUT_PARITY_EN
      err_par_q    <= err_par_d;
`endif
    end
  end

  assign out_data  = hold_data_q;
  assign out_slot  = hold_slot_q;
  assign out_valid = hold_valid_q;
  assign busy      = (state_q == ST_LEAD) || (state_q == ST_SHIFT);
  assign done      = done_q;
  assign err_ovf   = err_ovf_q;
  assign err_abort = err_abort_q;
`ifdef READOUT_PARITY_EN
  assign err_par   = err_par_q;
`endif

endmodule
